// File: rtl/pulse_stretcher_if.sv
// Request/status bundle for pulse_stretcher: request inputs from the master side,
// stretched level and queue status back from the stretcher.
interface pulse_stretcher_if #(
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned PEND_W = 3
) ();
  logic              pulse_in;
  logic [LEN_W-1:0]  length;
  logic              retrigger;
  logic              clear_ovf;
  logic              output_signal;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  modport master (
    output pulse_in, length, retrigger, clear_ovf,
    input  output_signal, busy, pending, overflow
  );

  modport slave (
    input  pulse_in, length, retrigger, clear_ovf,
    output output_signal, busy, pending, overflow
  );
endinterface

// File: rtl/pulse_stretcher.sv
// Pulse stretcher: IDLE/HOLD/GAP machine turning single-cycle requests into level
// pulses of programmable length, with a saturating request queue or retrigger mode.
module pulse_stretcher #(
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned PEND_W = 3,
  parameter int unsigned GAP    = 1
) (
  input logic               clk,
  input logic               reset,
  pulse_stretcher_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StHold, StGap} state_e;

  localparam logic [PEND_W-1:0] PendMax = '1;
  localparam logic [7:0]        GapLoad = 8'(GAP);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [7:0]        gap_cnt_q, gap_cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              out_q, out_d;
  logic [LEN_W-1:0]  len_eff;
  logic              req_inc, pend_dec, ovf_set;

  always_comb begin
    len_eff    = (bus.length == '0) ? LEN_W'(1) : bus.length;
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    pend_d     = pend_q;
    req_inc    = 1'b0;
    pend_dec   = 1'b0;
    ovf_set    = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.pulse_in) begin
          state_d    = StHold;
          hold_cnt_d = len_eff;
        end
      end
      StHold: begin
        if (bus.pulse_in && bus.retrigger) begin
          hold_cnt_d = len_eff;
        end else begin
          req_inc = bus.pulse_in;
          if (hold_cnt_q <= LEN_W'(1)) begin
            state_d   = StGap;
            gap_cnt_d = GapLoad;
          end else begin
            hold_cnt_d = hold_cnt_q - LEN_W'(1);
          end
        end
      end
      StGap: begin
        req_inc = bus.pulse_in;
        if (gap_cnt_q <= 8'd1) begin
          // A pulse on the exit edge counts as a queued request and is consumed at once.
          if (pend_q != '0 || bus.pulse_in) begin
            state_d    = StHold;
            hold_cnt_d = len_eff;
            pend_dec   = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (req_inc && !pend_dec) begin
      if (pend_q == PendMax) begin
        ovf_set = 1'b1;
      end else begin
        pend_d = pend_q + PEND_W'(1);
      end
    end else if (!req_inc && pend_dec) begin
      pend_d = pend_q - PEND_W'(1);
    end

    ovf_d = ovf_set ? 1'b1 : (bus.clear_ovf ? 1'b0 : ovf_q);
    out_d = (state_d == StHold);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      hold_cnt_q <= '0;
      gap_cnt_q  <= '0;
      pend_q     <= '0;
      ovf_q      <= 1'b0;
      out_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      pend_q     <= pend_d;
      ovf_q      <= ovf_d;
      out_q      <= out_d;
    end
  end

  assign bus.output_signal = out_q;
  assign bus.busy          = (state_q != StIdle);
  assign bus.pending       = pend_q;
  assign bus.overflow      = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher: stimulus pushes hand-derived per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pulse_stretcher;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pulse_stretcher_if #(.LEN_W(8), .PEND_W(3)) bus_if ();

  pulse_stretcher #(.LEN_W(8), .PEND_W(3), .GAP(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  typedef struct {
    string nm;
    int    cyc;
    bit    out;
    bit    busy;
    int    pend;
    bit    ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic string rep(input string s, input int n);
    string r = "";
    for (int i = 0; i < n; i++) r = {r, s};
    return r;
  endfunction

  function automatic bit chb(input string s, input int i);
    return (i < s.len()) && (s.getc(i) == 8'h31);
  endfunction

  task automatic chk(input string nm, input int cyc, input string what, input int got,
                     input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s[%0d] %s: got %0d expected %0d", nm, cyc, what, got, want);
    end
  endtask

  // Monitor: every cycle with an outstanding expectation is compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.nm, e.cyc, "output_signal", int'(bus_if.output_signal), int'(e.out));
      chk(e.nm, e.cyc, "busy", int'(bus_if.busy), int'(e.busy));
      chk(e.nm, e.cyc, "pending", int'(bus_if.pending), e.pend);
      chk(e.nm, e.cyc, "overflow", int'(bus_if.overflow), int'(e.ovf));
    end
  end

  // One character per clock edge; expectations describe the cycle after that edge.
  task automatic run(input string nm, input logic [7:0] len, input bit rt,
                     input string pul, input string rst, input string clr,
                     input string eo, input string eb, input string ep, input string ev);
    for (int i = 0; i < pul.len(); i++) begin
      exp_t e;
      bus_if.pulse_in  = chb(pul, i);
      bus_if.length    = len;
      bus_if.retrigger = rt;
      bus_if.clear_ovf = chb(clr, i);
      reset            = chb(rst, i);
      @(posedge clk);
      e.nm   = nm;
      e.cyc  = i;
      e.out  = chb(eo, i);
      e.busy = chb(eb, i);
      e.pend = int'(ep.getc(i)) - 48;
      e.ovf  = chb(ev, i);
      exp_q.push_back(e);
      #1;
    end
    bus_if.pulse_in  = 1'b0;
    bus_if.clear_ovf = 1'b0;
    reset            = 1'b0;
  endtask

  task automatic do_reset(input string nm);
    run(nm, 8'd1, 1'b0, "00", "11", "", "00", "00", "00", "00");
  endtask

  initial begin
    bus_if.pulse_in  = 1'b0;
    bus_if.length    = 8'd1;
    bus_if.retrigger = 1'b0;
    bus_if.clear_ovf = 1'b0;

    do_reset("reset_state");

    run("single_len5", 8'd5, 1'b0, "10000000", "", "",
        "11111000", "11111100", "00000000", "00000000");

    run("len_zero", 8'd0, 1'b0, "1000", "", "",
        "1000", "1100", "0000", "0000");

    run("queue3", 8'd3, 1'b0, "11100000000000", "", "",
        "11101110111000", "11111111111100", "01221111000000", "00000000000000");

    run("retrig4", 8'd4, 1'b1, "10100000", "", "",
        "11111100", "11111110", "00000000", "00000000");

    run("gap_exit_pulse", 8'd2, 1'b0, "1101000000", "", "",
        "1101101100", "1111111110", "0111110000", "0000000000");

    run("saturate", 8'd50, 1'b0,
        {rep("1", 10), rep("0", 46)}, "",
        {rep("0", 9), "101", rep("0", 44)},
        {rep("1", 50), "0", rep("1", 5)},
        rep("1", 56),
        {"01234567", rep("7", 43), rep("6", 5)},
        {rep("0", 8), rep("1", 3), rep("0", 45)});

    do_reset("reset_after_sat");

    run("reset_mid_hold", 8'd5, 1'b0, "111100000", "001000000", "",
        "110111110", "110111111", "010000000", "000000000");

    @(negedge clk);
    #1;
    chk("drain", 0, "queue_left", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pulse_stretcher.md
PULSE_STRETCHER -- requirements
Module: pulse_stretcher

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- LEN_W, 8, width of the length input and hold counter.
- PEND_W, 3, width of the pending-request counter.
- GAP, 1, minimum low cycles between back-to-back stretches (legal range 1 to 255).

REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, single clock; all logic on its rising edge.
- reset, in, 1, synchronous active-high reset.
- pulse_in, in, 1, single-cycle request pulse, already synchronous to clk.
- length, in, LEN_W, hold duration in cycles.
- retrigger, in, 1, mode select: 1 = retrigger, 0 = queue.
- clear_ovf, in, 1, clears the sticky overflow flag.
- output_signal, out, 1, stretched level output.
- busy, out, 1, high whenever the state is not IDLE.
- pending, out, PEND_W, count of queued requests.
- overflow, out, 1, sticky flag: a request was lost.

Function
REQ-003 The block SHALL be a three-state machine with states IDLE, HOLD and GAP, plus a hold counter (LEN_W bits), a gap counter and a pending counter.
REQ-004 output_signal SHALL be a registered output equal to 1 exactly when the state is HOLD.
REQ-005 In IDLE, pulse_in=1 sampled at edge k SHALL cause HOLD from edge k onward, so output_signal is high in the cycle after edge k (latency 1).
REQ-006 length SHALL be sampled on each entry into HOLD, and on each retrigger reload.
REQ-007 length=0 SHALL be treated as 1.
REQ-008 A stretch of length L SHALL hold output_signal high for exactly L consecutive cycles.
REQ-009 After HOLD the state SHALL always enter GAP, with output_signal low for exactly GAP cycles.
REQ-010 GAP SHALL exit to HOLD if pending>0, decrementing pending in the same edge; otherwise it SHALL exit to IDLE.
REQ-011 In retrigger mode, pulse_in=1 during HOLD SHALL reload the hold counter, so output stays high L more cycles counted from the cycle after the pulse, and pending SHALL be unchanged.
REQ-012 In retrigger mode, pulse_in=1 during GAP SHALL behave as in queue mode, incrementing pending.
REQ-013 In queue mode, pulse_in=1 during HOLD or GAP SHALL increment pending.
REQ-014 pending SHALL saturate at 2^PEND_W-1.
REQ-015 A pulse arriving while pending is saturated SHALL be dropped and SHALL set overflow.
REQ-016 Simultaneous increment and decrement of pending (pulse_in=1 on the GAP exit edge) SHALL leave pending unchanged, with the new stretch started.
REQ-017 A pulse on the last HOLD cycle SHALL count as a request during HOLD: it reloads in retrigger mode and queues in queue mode.
REQ-018 overflow SHALL remain set until clear_ovf=1 or reset.
REQ-019 clear_ovf and a new overflow event on the same edge SHALL leave overflow=1 (set wins).
REQ-020 retrigger SHALL be sampled every cycle; changing it mid-stretch affects only subsequent pulses.
REQ-021 busy SHALL be combinational from state; pending and overflow SHALL be registered.
REQ-022 Output timing SHALL guarantee that a rising-edge detector on output_signal sees one rising edge per stretch.

Reset
REQ-023 reset=1 at an edge SHALL force state to IDLE and clear every counter, giving output_signal=0, busy=0, pending=0 and overflow=0 after that edge.
REQ-024 Reset SHALL take priority over all other inputs, including mid-HOLD, mid-GAP, and a pulse_in on the same edge.
REQ-025 A pulse_in on the first edge after reset deasserts SHALL be accepted normally.

Verification
REQ-026 The bench SHALL cover the following directed scenarios, with GAP=1 unless stated:
- Single pulse, length=5 -> output_signal high for cycles 1..5 after the pulse edge, busy high for 6 cycles, pending=0.
- length=0, single pulse -> output_signal high for exactly 1 cycle.
- Queue mode, length=3, three pulses 1 cycle apart -> three 3-cycle highs separated by 1-cycle lows; pending peaks at 2, then returns to 0.
- Retrigger mode, length=4, second pulse 2 cycles after the first -> one continuous high of 6 cycles and no gap.
- Queue mode, PEND_W=3, 9 pulses during one long HOLD (length=50) -> pending=7 and overflow=1; after clear_ovf, overflow=0 while pending continues draining.
- Reset asserted mid-HOLD with pulse_in=1 on the same edge -> next cycle output_signal=0, busy=0, pending=0.
